fft4_serializer: RTL and testbench
==================================

Name: fft4_serializer

Overview:
- Unloads a 4-word parallel bundle (lanes a, b, c, d) as a serial word stream, one word per handshake.
- Bundles come from the radix-4 butterfly/Vedic multiplier pipeline stage registers.
- Drains to a narrow streaming consumer (output memory writer or next serial stage).
- Double-buffered (active + hold slot): sustains one word per cycle with back-to-back bundles.

Parameters:
- WIDTH, 12, bit width of each lane word and of out_data.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of both slots.
- in_valid  input  1  bundle on a/b/c/d is valid.
- in_ready  output  1  block can accept a bundle this cycle.
- a  input  WIDTH  lane 0 word.
- b  input  WIDTH  lane 1 word.
- c  input  WIDTH  lane 2 word.
- d  input  WIDTH  lane 3 word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  WIDTH  current serial word.
- out_idx  output  2  lane index of out_data (0=a .. 3=d).
- out_last  output  1  high with lane d (out_idx==3).
- busy  output  1  active or hold slot occupied.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All outputs are registered or derived only from registers; there is no combinational path from out_ready or in_valid to any output.
- Reset values: active_v=0, hold_v=0, idx=0, out_data=0, out_idx=0, out_valid=0, out_last=0, busy=0. in_ready=0 while rst is high, then 1.
- in_ready = !hold_v && !rst. Accept = in_valid && in_ready.
- xfer = out_valid && out_ready. end_b = xfer && idx==3.
- States: IDLE (active_v=0) and SHIFT (active_v=1). hold_v is an independent flag that is only set in SHIFT.
- IDLE + accept: load the active slot, idx=0, go to SHIFT. out_valid=1 with out_data=a on the next cycle (latency 1).
- SHIFT + xfer with idx<3: idx increments and out_data advances to the next lane. Order is a, b, c, d.
- SHIFT + accept while not end_b: the bundle goes into the hold slot and hold_v=1.
- end_b with hold_v=1: hold moves into active, idx=0, hold_v=0. out_valid stays 1 (no bubble). in_ready was 0 that cycle, so no simultaneous accept is possible.
- end_b with hold_v=0 and an accept in the same cycle: the bundle bypasses hold and loads active directly, idx=0, with no bubble.
- end_b with hold_v=0 and no accept: go to IDLE, out_valid=0.
- out_valid && !out_ready: out_data, out_idx and out_last are held stable. Input lanes are never sampled outside accept.
- flush (synchronous) has priority over accept and xfer. Next edge: active_v=0, hold_v=0, idx=0, out_valid=0. An in_valid presented in the flush cycle is dropped, but in_ready still reflects the pre-flush hold_v.
- Async reset mid-bundle abandons the bundle. Output resumes only after a fresh accept.
- busy = active_v || hold_v.
- Throughput: 4 cycles per bundle sustained when out_ready is held at 1. The producer sees in_ready=0 for at most 3 of every 4 cycles.
- No arithmetic. Words pass bit-exact; WIDTH is unchanged in and out.

Decomposition:
- Shared package fft_pkg:
  - WIDTH default 12.
  - LANES=4.
  - Lane-index typedef (2 bits).
  - Constant LAST_IDX=3.
- One sub-module: fft_bundle_slot, a 4×WIDTH register with load enable and synchronous clear.
  - Instantiated twice (active, hold).
  - A mux selects the active word by idx.

Test Plan:
1. Reset, then one bundle a=0x001, b=0x002, c=0x003, d=0xFFF with out_ready=1 → out_valid high cycles 1..4. Data 001, 002, 003, FFF with idx 0..3; out_last only on FFF; busy then 0.
2. Three back-to-back bundles, in_valid=1, out_ready=1 → 12 consecutive valid words with no bubble, in correct order. in_ready pattern 1,0,0,0 repeating after first fill.
3. out_ready=0 for 5 cycles mid-bundle (idx=1, data 0x0AB) → out_data, out_idx held at 0x0AB/1. Second bundle captured in hold; in_ready=0 until the end_b of the first bundle.
4. Bypass: with hold empty, in_valid on the same cycle as end_b (new a=0x555) → next cycle out_data=0x555, idx=0, out_valid never drops.
5. flush asserted with active at idx=2 and hold full → next cycle out_valid=0, busy=0, in_ready=1. Next bundle starts cleanly at idx=0.
6. rst asserted asynchronously mid-bundle → outputs go to reset values immediately, before the next clk edge; in_ready=0 during rst.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-4 bundle serializer.
// Lane 0 is word a and lane 3 is word d.
package fft_pkg;

  localparam int unsigned DEFAULT_WIDTH = 12;
  localparam int unsigned LANES         = 4;

  typedef logic [1:0] lane_idx_t;

  localparam lane_idx_t LAST_IDX = 2'd3;

  typedef enum logic {
    StIdle,
    StShift
  } ser_state_e;

endpackage

// File: rtl/fft_bundle_slot.sv
// One 4-lane bundle register.
// It has a load enable and a synchronous clear.
module fft_bundle_slot
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         load,
  input  logic [LANES-1:0][WIDTH-1:0]  din,
  output logic [LANES-1:0][WIDTH-1:0]  dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (clr) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/fft4_serializer.sv
// Serializes 4-word butterfly bundles into one word per handshake.
// An active slot and a hold slot let back-to-back bundles stream without bubbles.
module fft4_serializer
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy
);

  ser_state_e state;
  logic       hold_v;
  lane_idx_t  idx;
  lane_idx_t  next_idx;

  logic active_v;
  logic accept;
  logic xfer;
  logic end_b;
  logic active_load;
  logic hold_load;

  logic [LANES-1:0][WIDTH-1:0] in_words;
  logic [LANES-1:0][WIDTH-1:0] active_din;
  logic [LANES-1:0][WIDTH-1:0] active_words;
  logic [LANES-1:0][WIDTH-1:0] hold_words;

  assign in_words = {d, c, b, a};
  assign active_v = (state == StShift);

  assign in_ready = !hold_v && !rst;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign end_b    = xfer && (idx == LAST_IDX);
  assign next_idx = idx + 2'd1;

  // At the end of a bundle, the active slot refills from hold if it is full.
  // Otherwise a same-cycle accept refills the active slot directly.
  assign active_load = !flush && ((!active_v && accept) || (end_b && (hold_v || accept)));
  assign hold_load   = !flush && active_v && accept && !end_b;
  assign active_din  = hold_v ? hold_words : in_words;

  fft_bundle_slot #(
    .WIDTH (WIDTH)
  ) u_active_slot (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (active_load),
    .din  (active_din),
    .dout (active_words)
  );

  fft_bundle_slot #(
    .WIDTH (WIDTH)
  ) u_hold_slot (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (hold_load),
    .din  (in_words),
    .dout (hold_words)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      hold_v    <= 1'b0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= StIdle;
      hold_v    <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            state     <= StShift;
            idx       <= '0;
            out_data  <= a;
            out_valid <= 1'b1;
          end
        end
        StShift: begin
          if (hold_load) begin
            hold_v <= 1'b1;
          end
          if (end_b) begin
            idx <= '0;
            if (hold_v) begin
              out_data <= hold_words[0];
              hold_v   <= 1'b0;
            end else if (accept) begin
              out_data <= a;
            end else begin
              state     <= StIdle;
              out_valid <= 1'b0;
            end
          end else if (xfer) begin
            idx      <= next_idx;
            out_data <= active_words[next_idx];
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign out_idx  = idx;
  assign out_last = out_valid && (idx == LAST_IDX);
  assign busy     = active_v || hold_v;

endmodule

// File: tb/tb_fft4_serializer.sv
// Bench for fft4_serializer: a cycle vector table, hand-written corner sequences,
// and a word scoreboard fed on every accept.
module tb_fft4_serializer;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   out_idx;
  logic         out_last;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  fft4_serializer #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard: four words queued per accepted bundle, popped on each handshake.
  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   idx;
    logic         last;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_spurious: got word 0x%0h idx %0d, expected no word", out_data, out_idx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_word", {17'd0, out_data, out_idx, out_last}, {17'd0, e.data, e.idx, e.last});
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(exp_t'{data: a, idx: 2'd0, last: 1'b0});
        sb.push_back(exp_t'{data: b, idx: 2'd1, last: 1'b0});
        sb.push_back(exp_t'{data: c, idx: 2'd2, last: 1'b0});
        sb.push_back(exp_t'{data: d, idx: 2'd3, last: 1'b1});
      end
    end
  end

  // Per-cycle vector: inputs driven for the cycle, and the outputs expected in it.
  typedef struct {
    bit           iv;
    logic [W-1:0] va, vb, vc, vd;
    bit           ordy;
    bit           ev;
    logic [W-1:0] edata;
    logic [1:0]   eidx;
    bit           elast;
    bit           ebusy;
    bit           erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input bit iv, input logic [W-1:0] va, vb, vc, vd, input bit ordy,
                         input bit ev, input logic [W-1:0] ed, input logic [1:0] ei,
                         input bit el, input bit eb, input bit er);
    vec_t v;
    v.iv = iv; v.va = va; v.vb = vb; v.vc = vc; v.vd = vd; v.ordy = ordy;
    v.ev = ev; v.edata = ed; v.eidx = ei; v.elast = el; v.ebusy = eb; v.erdy = er;
    vecs.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] va, vb, vc, vd);
    in_valid = 1'b1;
    a = va; b = vb; c = vc; d = vd;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0;

    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {20'd0, out_data}, 32'd0);
    check("rst_out_idx", {30'd0, out_idx}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single bundle, then three back-to-back bundles.
    add_vec(1, 12'h001, 12'h002, 12'h003, 12'hFFF, 1, 0, 12'h000, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'h001, 0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'h002, 1, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'h003, 2, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'hFFF, 3, 1, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 0, 12'h000, 0, 0, 0, 1);
    add_vec(1, 12'h111, 12'h222, 12'h333, 12'h444, 1, 0, 12'h000, 0, 0, 0, 1);
    add_vec(1, 12'h5A5, 12'hA5A, 12'hFF0, 12'h00F, 1, 1, 12'h111, 0, 0, 1, 1);
    add_vec(1, 12'h123, 12'h456, 12'h789, 12'hABC, 1, 1, 12'h222, 1, 0, 1, 0);
    add_vec(1, 12'h123, 12'h456, 12'h789, 12'hABC, 1, 1, 12'h333, 2, 0, 1, 0);
    add_vec(1, 12'h123, 12'h456, 12'h789, 12'hABC, 1, 1, 12'h444, 3, 1, 1, 0);
    add_vec(1, 12'h123, 12'h456, 12'h789, 12'hABC, 1, 1, 12'h5A5, 0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'hA5A, 1, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'hFF0, 2, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'h00F, 3, 1, 1, 0);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'h123, 0, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'h456, 1, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'h789, 2, 0, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 1, 12'hABC, 3, 1, 1, 1);
    add_vec(0, 0, 0, 0, 0, 1, 0, 12'h000, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      in_valid = vecs[i].iv;
      a = vecs[i].va; b = vecs[i].vb; c = vecs[i].vc; d = vecs[i].vd;
      out_ready = vecs[i].ordy;
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].erdy});
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].ebusy});
      check($sformatf("vec%0d_out_last", i), {31'd0, out_last}, {31'd0, vecs[i].elast});
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_out_data", i), {20'd0, out_data}, {20'd0, vecs[i].edata});
        check($sformatf("vec%0d_out_idx", i), {30'd0, out_idx}, {30'd0, vecs[i].eidx});
      end
      cyc();
    end
    in_valid = 1'b0;

    // Stall mid-bundle with a second bundle captured in hold.
    put(12'h0AA, 12'h0AB, 12'h0AC, 12'h0AD);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    check("stall_in_ready_open", {31'd0, in_ready}, 32'd1);
    put(12'h1B0, 12'h1B1, 12'h1B2, 12'h1B3);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stall_data", {20'd0, out_data}, 32'h0AB);
      check("stall_idx", {30'd0, out_idx}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check("stall_resume_idx", {30'd0, out_idx}, i);
      check("stall_resume_in_ready", {31'd0, in_ready}, 32'd0);
      cyc();
    end
    check("hold_promote_data", {20'd0, out_data}, 32'h1B0);
    check("hold_promote_valid", {31'd0, out_valid}, 32'd1);
    check("hold_promote_in_ready", {31'd0, in_ready}, 32'd1);
    drain("stall_drain");

    // Bypass: accept on the same cycle as the last word, hold empty.
    put(12'h321, 12'h322, 12'h323, 12'h324);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("byp_valid", {31'd0, out_valid}, 32'd1);
      check("byp_idx", {30'd0, out_idx}, i);
      cyc();
    end
    check("byp_last_idx", {30'd0, out_idx}, 32'd3);
    check("byp_in_ready", {31'd0, in_ready}, 32'd1);
    put(12'h555, 12'h556, 12'h557, 12'h558);
    cyc();
    in_valid = 1'b0;
    check("byp_no_bubble", {31'd0, out_valid}, 32'd1);
    check("byp_data", {20'd0, out_data}, 32'h555);
    check("byp_idx0", {30'd0, out_idx}, 32'd0);
    drain("byp_drain");

    // Flush with active at idx 2 and hold full.
    put(12'h701, 12'h702, 12'h703, 12'h704);
    cyc();
    put(12'h801, 12'h802, 12'h803, 12'h804);
    cyc();
    in_valid = 1'b0;
    check("fl_hold_full", {31'd0, in_ready}, 32'd0);
    cyc();
    check("fl_idx2", {30'd0, out_idx}, 32'd2);
    flush = 1'b1;
    put(12'h901, 12'h902, 12'h903, 12'h904);
    check("fl_in_ready_pre", {31'd0, in_ready}, 32'd0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_busy", {31'd0, busy}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    put(12'hB01, 12'hB02, 12'hB03, 12'hB04);
    cyc();
    in_valid = 1'b0;
    check("fl_restart_valid", {31'd0, out_valid}, 32'd1);
    check("fl_restart_idx", {30'd0, out_idx}, 32'd0);
    check("fl_restart_data", {20'd0, out_data}, 32'hB01);
    drain("fl_drain");

    // Asynchronous reset mid-bundle.
    put(12'hC01, 12'hC02, 12'hC03, 12'hC04);
    cyc();
    in_valid = 1'b0;
    cyc();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", {20'd0, out_data}, 32'd0);
    check("arst_out_idx", {30'd0, out_idx}, 32'd0);
    check("arst_out_last", {31'd0, out_last}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    check("arst_no_resume", {31'd0, out_valid}, 32'd0);
    check("arst_idle", {31'd0, busy}, 32'd0);
    put(12'hD01, 12'hD02, 12'hD03, 12'hD04);
    cyc();
    in_valid = 1'b0;
    check("arst_fresh_data", {20'd0, out_data}, 32'hD01);
    check("arst_fresh_idx", {30'd0, out_idx}, 32'd0);
    drain("arst_drain");

    cyc();
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
